// File: rtl/mod_n_counter.sv
// Modulo-N up-counter with enable, synchronous clear to INIT and terminal-count flag.
// Define MODN_COUNTER_ASSERT_EN (without SYNTHESIS) to compile the parameter and behaviour checks.

`ifdef MODN_COUNTER_ASSERT_EN
`ifndef SYNTHESIS
module mod_n_counter_chk #(
   parameter int unsigned N    = 4,
   parameter int unsigned INIT = 0
) (
   input logic                 clk_i,
   input logic                 rst_ni,
   input logic                 en_i,
   input logic                 clr_i,
   input logic [$clog2(N)-1:0] count_i,
   input logic                 tc_i
);
   localparam int unsigned W      = $clog2(N);
   localparam logic [W-1:0] MAX_C  = W'(N - 1);
   localparam logic [W-1:0] INIT_C = W'(INIT);
   localparam logic [W-1:0] ZERO_C = {W{1'b0}};
   localparam logic [W-1:0] ONE_C  = W'(1'b1);

   if (N < 2) begin : g_bad_n
      $fatal(1, "mod_n_counter: N must be at least 2");
   end
   if (INIT >= N) begin : g_bad_init
      $fatal(1, "mod_n_counter: INIT must be below N");
   end

   logic [W-1:0] exp_inc_s;

   // Reference successor of the current count, sampled with $past below.
   always_comb begin
      if (count_i == MAX_C) begin
         exp_inc_s = ZERO_C;
      end else begin
         exp_inc_s = count_i + ONE_C;
      end
   end

   a_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
      int'(count_i) < int'(N));
   a_inc: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (en_i && !clr_i) |=> (count_i == $past(exp_inc_s)));
   a_clr: assert property (@(posedge clk_i) disable iff (!rst_ni)
      clr_i |=> (count_i == INIT_C));
   a_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (!en_i && !clr_i) |=> $stable(count_i));
   a_tc: assert property (@(posedge clk_i) disable iff (!rst_ni)
      tc_i == (count_i == MAX_C));
endmodule
`endif
`endif

module mod_n_counter #(
   parameter int unsigned N    = 4,
   parameter int unsigned INIT = 0
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 en_i,
   input  logic                 clr_i,
   output logic [$clog2(N)-1:0] count_o,
   output logic                 tc_o
);
   localparam int unsigned W      = $clog2(N);
   localparam logic [W-1:0] MAX_C  = W'(N - 1);
   localparam logic [W-1:0] INIT_C = W'(INIT);
   localparam logic [W-1:0] ZERO_C = {W{1'b0}};
   localparam logic [W-1:0] ONE_C  = W'(1'b1);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // Explicit wrap so non-power-of-two moduli never reach N..2^W-1.
   function automatic logic [W-1:0] next_idx(input logic [W-1:0] cur);
      if (cur == MAX_C) begin
         return ZERO_C;
      end else begin
         return cur + ONE_C;
      end
   endfunction

   // Next-state selection: clear beats enable, otherwise hold.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = INIT_C;
      end else if (en_i) begin
         cnt_d = next_idx(cnt_q);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Counter register with asynchronous reset to INIT.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= INIT_C;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign count_o = cnt_q;
   assign tc_o    = (cnt_q == MAX_C);

`ifdef MODN_COUNTER_ASSERT_EN
`ifndef SYNTHESIS
   mod_n_counter_chk #(.N(N), .INIT(INIT)) u_chk (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .en_i    (en_i),
      .clr_i   (clr_i),
      .count_i (cnt_q),
      .tc_i    (tc_o)
   );
`endif
`endif
endmodule

// File: tb/tb_mod_n_counter.sv
// Scoreboard bench for mod_n_counter: four instances with different N/INIT, directed vectors.
module tb_mod_n_counter;
   logic clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   logic [3:0] rst_n = 4'b1111;
   logic [3:0] en    = 4'b0000;
   logic [3:0] clr   = 4'b0000;

   logic [1:0] cnt_a, cnt_b;
   logic [2:0] cnt_c, cnt_d;
   logic       tc_a, tc_b, tc_c, tc_d;

   mod_n_counter #(.N(4), .INIT(1)) u_a (.clk_i(clk_i), .rst_ni(rst_n[0]), .en_i(en[0]),
      .clr_i(clr[0]), .count_o(cnt_a), .tc_o(tc_a));
   mod_n_counter #(.N(4), .INIT(0)) u_b (.clk_i(clk_i), .rst_ni(rst_n[1]), .en_i(en[1]),
      .clr_i(clr[1]), .count_o(cnt_b), .tc_o(tc_b));
   mod_n_counter #(.N(5), .INIT(0)) u_c (.clk_i(clk_i), .rst_ni(rst_n[2]), .en_i(en[2]),
      .clr_i(clr[2]), .count_o(cnt_c), .tc_o(tc_c));
   mod_n_counter #(.N(8), .INIT(0)) u_d (.clk_i(clk_i), .rst_ni(rst_n[3]), .en_i(en[3]),
      .clr_i(clr[3]), .count_o(cnt_d), .tc_o(tc_d));

   typedef struct {
      int    id;
      int    cnt;
      bit    tc;
      string tag;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;
   event async_ev;

   task automatic get_act(input int id, output logic [2:0] c, output logic t);
      case (id)
         0:       begin c = {1'b0, cnt_a}; t = tc_a; end
         1:       begin c = {1'b0, cnt_b}; t = tc_b; end
         2:       begin c = cnt_c; t = tc_c; end
         default: begin c = cnt_d; t = tc_d; end
      endcase
   endtask

   // Monitor: one expectation is due after each clock edge or async-reset event.
   initial begin
      exp_t       e;
      logic [2:0] ac;
      logic       at;
      forever begin
         @(posedge clk_i or async_ev);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            get_act(e.id, ac, at);
            checks++;
            if (ac !== 3'(e.cnt) || at !== e.tc) begin
               failures++;
               $display("FAIL %s: dut%0d count=%0d tc=%0b, required count=%0d tc=%0b",
                        e.tag, e.id, ac, at, e.cnt, e.tc);
            end
         end
      end
   end

   task automatic step(input int id, input bit e, input bit c, input int exp_cnt,
                       input bit exp_tc, input string tag);
      @(negedge clk_i);
      en[id]  = e;
      clr[id] = c;
      sb.push_back('{id, exp_cnt, exp_tc, tag});
   endtask

   task automatic idle(input int id);
      @(negedge clk_i);
      en[id]  = 1'b0;
      clr[id] = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 50 && sb.size() > 0; i++) @(negedge clk_i);
      if (sb.size() > 0) begin
         checks++;
         failures++;
         $display("FAIL drain_timeout: pending=%0d, required 0", sb.size());
         sb.delete();
      end
   endtask

   // Pulse reset low between edges, check without a clock, then check the first edge after release.
   task automatic async_pulse(input int id, input bit e, input int exp_cnt, input bit exp_tc,
                              input int post_cnt, input bit post_tc, input string tag);
      drain();
      @(negedge clk_i);
      en[id]  = e;
      clr[id] = 1'b0;
      #2;
      rst_n[id] = 1'b0;
      sb.push_back('{id, exp_cnt, exp_tc, {tag, "_async"}});
      -> async_ev;
      #2;
      rst_n[id] = 1'b1;
      sb.push_back('{id, post_cnt, post_tc, {tag, "_post"}});
   endtask

   initial begin
      // Reset state of every instance (A: N=4 INIT=1, others INIT=0)
      async_pulse(0, 1'b0, 1, 1'b0, 1, 1'b0, "rst_a");
      async_pulse(1, 1'b0, 0, 1'b0, 0, 1'b0, "rst_b");
      async_pulse(2, 1'b0, 0, 1'b0, 0, 1'b0, "rst_c");
      async_pulse(3, 1'b0, 0, 1'b0, 0, 1'b0, "rst_d");

      // A holds at INIT while disabled
      for (int i = 0; i < 3; i++) step(0, 1'b0, 1'b0, 1, 1'b0, "hold_a");

      // B: N=4 wrap
      step(1, 1'b1, 1'b0, 1, 1'b0, "wrap4");
      step(1, 1'b1, 1'b0, 2, 1'b0, "wrap4");
      step(1, 1'b1, 1'b0, 3, 1'b1, "wrap4");
      step(1, 1'b1, 1'b0, 0, 1'b0, "wrap4");
      step(1, 1'b1, 1'b0, 1, 1'b0, "wrap4");
      step(1, 1'b1, 1'b0, 2, 1'b0, "wrap4");
      idle(1);

      // C: N=5 wrap
      step(2, 1'b1, 1'b0, 1, 1'b0, "wrap5");
      step(2, 1'b1, 1'b0, 2, 1'b0, "wrap5");
      step(2, 1'b1, 1'b0, 3, 1'b0, "wrap5");
      step(2, 1'b1, 1'b0, 4, 1'b1, "wrap5");
      step(2, 1'b1, 1'b0, 0, 1'b0, "wrap5");
      step(2, 1'b1, 1'b0, 1, 1'b0, "wrap5");
      step(2, 1'b1, 1'b0, 2, 1'b0, "wrap5");
      idle(2);

      // A: clear beats enable, loads INIT=1
      step(0, 1'b1, 1'b0, 2, 1'b0, "pre_clr");
      step(0, 1'b1, 1'b0, 3, 1'b1, "pre_clr");
      step(0, 1'b1, 1'b1, 1, 1'b0, "clr_prio");
      step(0, 1'b1, 1'b0, 2, 1'b0, "post_clr");
      idle(0);

      // D: N=8 enable gating, tc independent of en
      for (int v = 1; v <= 5; v++) step(3, 1'b1, 1'b0, v, 1'b0, "pre_gate");
      step(3, 1'b1, 1'b0, 6, 1'b0, "gate");
      step(3, 1'b0, 1'b0, 6, 1'b0, "gate");
      step(3, 1'b0, 1'b0, 6, 1'b0, "gate");
      step(3, 1'b1, 1'b0, 7, 1'b1, "gate");
      step(3, 1'b0, 1'b0, 7, 1'b1, "tc_no_en");
      step(3, 1'b1, 1'b0, 0, 1'b0, "wrap8");
      idle(3);

      // B sits at 2; async reset while enabled, then first edge counts to 1
      async_pulse(1, 1'b1, 0, 1'b0, 1, 1'b0, "midrst");
      idle(1);

      drain();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/mod_n_counter.md
# mod_n_counter

Synchronous modulo-N up-counter with enable, synchronous clear to a programmable initial value, and a terminal-count flag. Used throughout the execution pipeline as a circular index generator, e.g. ROB tail, clear and work pointers. A non-zero `INIT` supports look-ahead pointers that start one slot ahead of another pointer.

## Interface
- `N`, default 4: modulus; legal range N ≥ 2; need not be a power of two.
- `INIT`, default 0: value loaded at reset and on clear; legal range 0 ≤ INIT ≤ N-1.
- `clk_i`  input  1  clock; all state updates on rising edge.
- `rst_ni`  input  1  reset; asynchronous, active-low; clock clk_i.
- `en_i`  input  1  count enable; increments by one per enabled cycle.
- `clr_i`  input  1  synchronous clear; loads INIT.
- `count_o`  output  $clog2(N)  current count, registered.
- `tc_o`  output  1  terminal count; high while count_o == N-1.

## Operation
- State: one register `cnt` of width W = $clog2(N); `count_o` drives `cnt` directly.
- Per-cycle update priority, evaluated at each rising edge:
  - rst_ni low: cnt = INIT, asynchronously, regardless of the clock.
  - Else if clr_i = 1: cnt = INIT. The clear overrides en_i.
  - Else if en_i = 1 and cnt == N-1: cnt = 0, i.e. wrap-around.
  - Else if en_i = 1: cnt = cnt + 1. Arithmetic is W bits; no overflow is possible because cnt < N ≤ 2^W.
  - Else: cnt holds.
- tc_o = (cnt == N-1).
  - Purely combinational from the register.
  - Not qualified by en_i.
- Non-power-of-two N: values N..2^W-1 are unreachable. The wrap compare is explicit and does not rely on natural overflow.
- Constants N-1 and INIT are truncated/cast to W bits for comparison and load.
- No other state; no FSM beyond the counter register.

## Timing
- Reset values:
  - count_o = INIT.
  - tc_o = 1 if INIT == N-1, else 0.
- Reset assertion takes effect immediately. On deassertion, the counter resumes on the first rising edge where rst_ni is high.
- Latency: en_i or clr_i sampled at edge k; count_o reflects the result after edge k. tc_o follows count_o in the same cycle with combinational delay only.
- clr_i and en_i both high: result is INIT, and no increment occurs that cycle.
- Reset mid-count: count returns to INIT immediately; any pending en_i/clr_i is ignored while rst_ni is low.
- Enable held continuously: sequence INIT, INIT+1, …, N-1, 0, 1, … with period N.

## Configuration
- Macro `MODN_COUNTER_ASSERT_EN`.
- Defined, and SYNTHESIS not defined:
  - Elaboration-time checks that N ≥ 2 and INIT < N; a violation is a fatal error.
  - Concurrent assertions, disabled while rst_ni is low:
    - count_o < N at every edge.
    - With en_i & ~clr_i, the next count equals (count+1) mod N.
    - With clr_i, the next count equals INIT.
    - With ~en_i & ~clr_i, the count is stable.
    - tc_o == (count_o == N-1).
- Not defined: no checks are compiled. Functional behaviour is identical.

## Test plan
- Reset: N=4, INIT=1. Assert rst_ni low mid-cycle → count_o=1 immediately, tc_o=0. Release; with en_i=0 for 3 cycles → count_o stays 1.
- Wrap, power of two: N=4, INIT=0, en_i=1 for 6 cycles → count_o 1,2,3,0,1,2. tc_o=1 only in the cycle count_o=3.
- Wrap, non-power of two: N=5, INIT=0, en_i=1 for 7 cycles → 1,2,3,4,0,1,2. Value never exceeds 4; tc_o high at 4.
- Clear priority: N=4, INIT=1, count at 3. Set clr_i=1 and en_i=1 for one cycle → count_o=1. Next cycle with en_i=1 only → 2.
- Enable gating: N=8, count at 5, en_i toggled 1,0,0,1 → 6,6,6,7. tc_o rises with 7 and is independent of en_i.
- Async reset during counting: N=4, INIT=0, count at 2 with en_i=1. Pulse rst_ni low between edges → count_o=0 without a clock edge. First enabled edge after release → 1.
